// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, the default NOP word
// and the IF/ID register occupancy states.
package cpu_pkg;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int IMM16_HI = 15;
  localparam int IMM16_LO = 0;
  localparam int IMM26_HI = 25;
  localparam int IMM26_LO = 0;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  // Occupancy of the IF/ID register: nothing, main slot only, main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_slot.sv
// One {valid, pc, ir} holding slot; clear wins over load and returns the
// slot to its empty value (pc 0, ir = NOP).
module pipe_slot
  import cpu_pkg::*;
#(
  parameter int                INSN_W   = 32,
  parameter int                PC_W     = 32,
  parameter logic [INSN_W-1:0] NOP_INSN = INSN_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [INSN_W-1:0] d_ir,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [INSN_W-1:0] ir
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      ir    <= NOP_INSN;
    end else if (clear) begin
      valid <= 1'b0;
      pc    <= '0;
      ir    <= NOP_INSN;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= d_pc;
      ir    <= d_ir;
    end
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register: valid/ready on both sides, optional one-entry skid
// slot so if_ready is a registered signal, flush, and decode field slicing.
module if_id_pipe_reg
  import cpu_pkg::*;
#(
  parameter int                INSN_W   = 32,
  parameter int                PC_W     = 32,
  parameter logic [INSN_W-1:0] NOP_INSN = INSN_W'(NOP_DEFAULT),
  parameter bit                SKID_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [INSN_W-1:0] if_ir,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [PC_W-1:0]   id_pc,
  output logic [INSN_W-1:0] id_ir,
  output logic [5:0]        id_opcode,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_rd,
  output logic [15:0]       id_imm16,
  output logic [25:0]       id_imm26,
  output state_e            fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high on that side; valid never depends on ready of the same side.
  logic accept, consume;
  logic main_load, main_clear, skid_load, skid_clear;
  logic skid_valid;
  logic [PC_W-1:0]   skid_pc, main_d_pc;
  logic [INSN_W-1:0] skid_ir, main_d_ir;
  state_e state, next_state;
  logic if_ready_r;

  assign accept  = if_valid && if_ready;
  assign consume = id_valid && id_ready;

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    next_state = state;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_load  = 1'b1;
          next_state = ONE;
        end
        ONE: begin
          if (consume && accept) main_load = 1'b1;
          else if (consume) begin
            main_clear = 1'b1;
            next_state = EMPTY;
          end else if (accept) begin
            skid_load  = 1'b1;
            next_state = TWO;
          end
        end
        TWO: if (consume) begin
          main_load  = 1'b1;
          skid_clear = 1'b1;
          next_state = ONE;
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  // Main refills from the skid slot whenever it holds the older instruction.
  assign main_d_pc = skid_valid ? skid_pc : if_pc;
  assign main_d_ir = skid_valid ? skid_ir : if_ir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      if_ready_r <= 1'b1;
    end else begin
      state      <= next_state;
      if_ready_r <= (next_state != TWO);
    end
  end

  assign fsm_state = state;

  pipe_slot #(.INSN_W(INSN_W), .PC_W(PC_W), .NOP_INSN(NOP_INSN)) u_main (
    .clk(clk), .rst_n(rst_n), .load(main_load), .clear(main_clear),
    .d_pc(main_d_pc), .d_ir(main_d_ir),
    .valid(id_valid), .pc(id_pc), .ir(id_ir)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_slot #(.INSN_W(INSN_W), .PC_W(PC_W), .NOP_INSN(NOP_INSN)) u_skid (
        .clk(clk), .rst_n(rst_n), .load(skid_load), .clear(skid_clear),
        .d_pc(if_pc), .d_ir(if_ir),
        .valid(skid_valid), .pc(skid_pc), .ir(skid_ir)
      );
      assign if_ready = if_ready_r;
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_pc    = '0;
      assign skid_ir    = NOP_INSN;
      assign if_ready   = !id_valid || id_ready;
    end
  endgenerate

  assign id_opcode = id_ir[OPC_HI:OPC_LO];
  assign id_rs     = id_ir[RS_HI:RS_LO];
  assign id_rt     = id_ir[RT_HI:RT_LO];
  assign id_rd     = id_ir[RD_HI:RD_LO];
  assign id_imm16  = id_ir[IMM16_HI:IMM16_LO];
  assign id_imm26  = id_ir[IMM26_HI:IMM26_LO];

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: a skid instance and a no-skid instance share the
// same stimulus and are each compared against a queue-based occupancy model.
module tb_if_id_pipe_reg;
  import cpu_pkg::*;

  localparam logic [31:0] NOP0 = 32'h0000_0020;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_valid = 1'b0, flush = 1'b0, id_ready = 1'b0;
  logic [31:0] if_pc = '0, if_ir = '0;

  logic        a_if_ready, a_id_valid, b_if_ready, b_id_valid;
  logic [31:0] a_id_pc, a_id_ir, b_id_pc, b_id_ir;
  logic [5:0]  a_opc, b_opc;
  logic [4:0]  a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;
  logic [15:0] a_imm16, b_imm16;
  logic [25:0] a_imm26, b_imm26;
  state_e      a_state, b_state;

  always #5 clk = ~clk;

  if_id_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(a_if_ready),
    .if_pc(if_pc), .if_ir(if_ir), .flush(flush), .id_valid(a_id_valid),
    .id_ready(id_ready), .id_pc(a_id_pc), .id_ir(a_id_ir), .id_opcode(a_opc),
    .id_rs(a_rs), .id_rt(a_rt), .id_rd(a_rd), .id_imm16(a_imm16),
    .id_imm26(a_imm26), .fsm_state(a_state)
  );

  if_id_pipe_reg #(.NOP_INSN(NOP0), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(b_if_ready),
    .if_pc(if_pc), .if_ir(if_ir), .flush(flush), .id_valid(b_id_valid),
    .id_ready(id_ready), .id_pc(b_id_pc), .id_ir(b_id_ir), .id_opcode(b_opc),
    .id_rs(b_rs), .id_rt(b_rt), .id_rd(b_rd), .id_imm16(b_imm16),
    .id_imm26(b_imm26), .fsm_state(b_state)
  );

  // Scoreboards: instructions currently held, oldest first, as {pc, ir}.
  logic [63:0] exp_q[$];
  logic [63:0] exp0_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] head_ir(input logic [63:0] q[$], input logic [31:0] nop);
    return (q.size() > 0) ? q[0][31:0] : nop;
  endfunction

  function automatic logic [31:0] head_pc(input logic [63:0] q[$]);
    return (q.size() > 0) ? q[0][63:32] : 32'h0;
  endfunction

  task automatic check_outputs();
    logic [31:0] ea, eb;
    ea = head_ir(exp_q, 32'h0);
    eb = head_ir(exp0_q, NOP0);
    chk("skid id_valid", a_id_valid, exp_q.size() > 0);
    chk("skid id_pc",    a_id_pc, head_pc(exp_q));
    chk("skid id_ir",    a_id_ir, ea);
    chk("skid if_ready", a_if_ready, exp_q.size() < 2);
    chk("skid state",    a_state, exp_q.size());
    chk("skid opcode",   a_opc, ea >> 26);
    chk("skid rs",       a_rs, (ea >> 21) & 32'h1f);
    chk("skid rt",       a_rt, (ea >> 16) & 32'h1f);
    chk("skid rd",       a_rd, (ea >> 11) & 32'h1f);
    chk("skid imm16",    a_imm16, ea & 32'hffff);
    chk("skid imm26",    a_imm26, ea & 32'h3ff_ffff);
    chk("noskid id_valid", b_id_valid, exp0_q.size() > 0);
    chk("noskid id_pc",    b_id_pc, head_pc(exp0_q));
    chk("noskid id_ir",    b_id_ir, eb);
    chk("noskid if_ready", b_if_ready, (exp0_q.size() == 0) || id_ready);
    chk("noskid opcode",   b_opc, eb >> 26);
    chk("noskid rd",       b_rd, (eb >> 11) & 32'h1f);
    chk("noskid imm16",    b_imm16, eb & 32'hffff);
  endtask

  // Drive one cycle of inputs, check combinational ready, clock, update models, check.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                      input logic rdy, input logic fl);
    logic acc, con, acc0, con0;
    if_valid = v; if_pc = pc; if_ir = ir; id_ready = rdy; flush = fl;
    #1;
    chk("skid if_ready pre", a_if_ready, exp_q.size() < 2);
    chk("noskid if_ready pre", b_if_ready, (exp0_q.size() == 0) || rdy);
    acc  = v && (exp_q.size() < 2);
    con  = rdy && (exp_q.size() > 0);
    acc0 = v && ((exp0_q.size() == 0) || rdy);
    con0 = rdy && (exp0_q.size() > 0);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      exp0_q.delete();
    end else begin
      if (con)  void'(exp_q.pop_front());
      if (acc)  exp_q.push_back({pc, ir});
      if (con0) void'(exp0_q.pop_front());
      if (acc0) exp0_q.push_back({pc, ir});
    end
    #1;
    check_outputs();
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        rdy;
    logic        fl;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic        e_ifr;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b1, 32'h00, 32'h8C220004, 1'b1, 1'b0, 1'b1, 32'h00, 32'h8C220004, 1'b1};
    tbl[1]  = '{1'b1, 32'h04, 32'h00430820, 1'b1, 1'b0, 1'b1, 32'h04, 32'h00430820, 1'b1};
    tbl[2]  = '{1'b1, 32'h08, 32'h1000FFFF, 1'b1, 1'b0, 1'b1, 32'h08, 32'h1000FFFF, 1'b1};
    tbl[3]  = '{1'b0, 32'h00, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00, 32'h00000000, 1'b1};
    tbl[4]  = '{1'b1, 32'h00, 32'h24010005, 1'b0, 1'b0, 1'b1, 32'h00, 32'h24010005, 1'b1};
    tbl[5]  = '{1'b1, 32'h04, 32'h02114020, 1'b0, 1'b0, 1'b1, 32'h00, 32'h24010005, 1'b0};
    tbl[6]  = '{1'b1, 32'h08, 32'h08000010, 1'b0, 1'b0, 1'b1, 32'h00, 32'h24010005, 1'b0};
    tbl[7]  = '{1'b1, 32'h08, 32'h08000010, 1'b1, 1'b0, 1'b1, 32'h04, 32'h02114020, 1'b1};
    tbl[8]  = '{1'b1, 32'h08, 32'h08000010, 1'b1, 1'b0, 1'b1, 32'h08, 32'h08000010, 1'b1};
    tbl[9]  = '{1'b0, 32'h00, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h08, 32'h08000010, 1'b1};
    tbl[10] = '{1'b1, 32'h0C, 32'h3C01ABCD, 1'b0, 1'b0, 1'b1, 32'h08, 32'h08000010, 1'b0};
    tbl[11] = '{1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h00, 32'h00000000, 1'b1};
    tbl[12] = '{1'b0, 32'h00, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00, 32'h00000000, 1'b1};
    tbl[13] = '{1'b1, 32'h14, 32'hAC450008, 1'b1, 1'b0, 1'b1, 32'h14, 32'hAC450008, 1'b1};
    tbl[14] = '{1'b0, 32'h00, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00, 32'h00000000, 1'b1};

    // Reset values while reset is held.
    #12;
    check_outputs();
    chk("reset noskid id_ir nop", b_id_ir, 32'h20);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].pc, tbl[i].ir, tbl[i].rdy, tbl[i].fl);
      chk($sformatf("tbl[%0d] id_valid", i), a_id_valid, tbl[i].e_valid);
      chk($sformatf("tbl[%0d] id_pc", i), a_id_pc, tbl[i].e_pc);
      chk($sformatf("tbl[%0d] id_ir", i), a_id_ir, tbl[i].e_ir);
      chk($sformatf("tbl[%0d] if_ready", i), a_if_ready, tbl[i].e_ifr);
      if (i == 0) begin
        chk("lw opcode", a_opc, 6'h23);
        chk("lw rs", a_rs, 5'd1);
        chk("lw rt", a_rt, 5'd2);
        chk("lw imm16", a_imm16, 16'h0004);
      end
    end

    // No-skid instance: held instruction with id_ready low blocks if_ready.
    step(1'b1, 32'h40, 32'h11112222, 1'b0, 1'b0);
    if_valid = 1'b0; id_ready = 1'b0;
    #1;
    chk("noskid stall if_ready", b_if_ready, 1'b0);
    id_ready = 1'b1;
    #1;
    chk("noskid release if_ready", b_if_ready, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("noskid empty id_ir", b_id_ir, 32'h20);

    // Async reset pulse between edges with instructions held.
    step(1'b1, 32'h50, 32'h33334444, 1'b0, 1'b0);
    step(1'b1, 32'h54, 32'h55556666, 1'b0, 1'b0);
    if_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst skid id_valid", a_id_valid, 1'b0);
    chk("async rst skid id_pc", a_id_pc, 32'h0);
    chk("async rst skid if_ready", a_if_ready, 1'b1);
    chk("async rst noskid id_valid", b_id_valid, 1'b0);
    chk("async rst noskid id_ir", b_id_ir, 32'h20);
    exp_q.delete();
    exp0_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'h60, 32'h77778888, 1'b1, 1'b0);
    chk("post rst first pc", a_id_pc, 32'h60);

    // Randomized traffic against the occupancy model.
    for (int n = 0; n < 500; n++) begin
      step($urandom_range(0, 9) < 7, {$urandom_range(0, 1023), 2'b00}, $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
